// File: rtl/writeback_queue.sv
// In-order writeback FIFO feeding the register file write port, with operand bypass lookup.
// Define WBQ_FWD_EN to build the forwarding comparators; otherwise fwd_* outputs are tied to 0.
module writeback_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDR_W-1:0]        mem_reg,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_reg,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     wb_stall,
  output logic                     rf_reg_write,
  output logic [ADDR_W-1:0]        rf_write_reg,
  output logic [DATA_W-1:0]        rf_write_data,
  input  logic [ADDR_W-1:0]        fwd_reg1,
  input  logic [ADDR_W-1:0]        fwd_reg2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [DATA_W-1:0]        fwd_data1,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]   head_q, tail_q;
  logic [CntW-1:0]   count_q;
  logic [ADDR_W-1:0] reg_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic              push_mem, push_alu, push, pop, empty;
  logic [ADDR_W-1:0] in_reg;
  logic [DATA_W-1:0] in_data;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CntW'(DEPTH));
  assign count     = count_q;
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;

  assign push_mem = mem_valid && mem_ready;
  assign push_alu = alu_valid && alu_ready;
  assign in_reg   = push_mem ? mem_reg : alu_reg;
  assign in_data  = push_mem ? mem_data : alu_data;
  // Results for R0 are handshaken but dropped.
  assign push     = (push_mem || push_alu) && (in_reg != '0);
  assign pop      = !empty && !wb_stall;

  assign rf_reg_write  = pop;
  assign rf_write_reg  = empty ? '0 : reg_q[head_q];
  assign rf_write_data = empty ? '0 : data_q[head_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      reg_q[tail_q]  <= in_reg;
      data_q[tail_q] <= in_data;
    end
  end

`ifdef WBQ_FWD_EN
  logic [PtrW-1:0] idx;

  // Walk oldest to youngest so the youngest match overrides earlier ones.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    idx       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if (CntW'(i) < count_q) begin
        if (fwd_reg1 != '0 && reg_q[idx] == fwd_reg1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = data_q[idx];
        end
        if (fwd_reg2 != '0 && reg_q[idx] == fwd_reg2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = data_q[idx];
        end
      end
    end
  end
`else
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Write-side initiator for the 16x16 register file. It accepts results from the ALU and memory stages over valid/ready handshakes and buffers them in a small in-order FIFO. It drains one entry per cycle onto the register file write port (`reg_write`/`write_reg`/`write_data`). Pending entries are bypassed to operand-read lookups, so younger instructions see results that have not yet been written.

## Interface
- `DEPTH`, 4, number of FIFO entries; power of two, minimum 2
- `DATA_W`, 16, result data width; matches register width
- `ADDR_W`, 4, register index width; 16 registers

Ports:
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `mem_valid`  in  1  memory-stage result valid
- `mem_ready`  out  1  memory result accepted this cycle
- `mem_reg`  in  ADDR_W  destination register for the memory result
- `mem_data`  in  DATA_W  memory result data
- `alu_valid`  in  1  ALU result valid
- `alu_ready`  out  1  ALU result accepted this cycle
- `alu_reg`  in  ADDR_W  destination register for the ALU result
- `alu_data`  in  DATA_W  ALU result data
- `wb_stall`  in  1  hold the FIFO head; no drain this cycle
- `rf_reg_write`  out  1  drives register file `reg_write`
- `rf_write_reg`  out  ADDR_W  drives register file `write_reg`
- `rf_write_data`  out  DATA_W  drives register file `write_data`
- `fwd_reg1`, `fwd_reg2`  in  ADDR_W  registers being read by the operand stage
- `fwd_hit1`, `fwd_hit2`  out  1  a pending entry matches the lookup
- `fwd_data1`, `fwd_data2`  out  DATA_W  value of the youngest matching entry
- `count`  out  $clog2(DEPTH)+1  current occupancy
- `full`  out  1  `count == DEPTH`

## Operation
- **FIFO storage.** Circular buffer with head and tail pointers plus an occupancy counter. Pointers wrap modulo `DEPTH`.
- **Arbitration.** At most one enqueue per cycle, and memory has fixed priority.
  - `mem_ready = !full`.
  - `alu_ready = !full && !mem_valid`.
  - A transfer occurs when valid and ready are both high at the rising edge.
- **R0 filter.** An accepted result with destination register 0 is consumed (ready high) but never stored. `count` does not change.
- **Drain.**
  - `rf_reg_write = (count != 0) && !wb_stall`.
  - `rf_write_reg` and `rf_write_data` always show the head entry. Both are 0 when the FIFO is empty.
  - The head is popped at every edge where `rf_reg_write` is high.
- **Simultaneous push and pop.** Allowed whenever not full, and `count` is unchanged. When full, ready is low even if a pop occurs in the same cycle; there is no combinational pass-through from the pop side to ready.
- **Forwarding lookup** (combinational, over valid entries only):
  - Matches are searched from youngest to oldest.
  - The head is included even while it is being written.
  - A result being enqueued in the same cycle is not visible to the lookup.
  - A lookup of register 0 gives `fwd_hit = 0` and `fwd_data = 0`.
  - On a miss, `fwd_data = 0`.

## Timing
- **Reset.** Asynchronous assertion clears pointers and `count` and discards all pending entries.
  - All outputs go to 0 immediately: `rf_reg_write`, `rf_write_reg`, `rf_write_data`, `fwd_*`, `count`, `full`.
  - `mem_ready` and `alu_ready` go to 1; `alu_ready` is still gated by `mem_valid`.
- **Reset release.** Release is synchronous to `clk` at the next edge.
- **Latency.**
  - A result accepted at edge N appears on `rf_*` in cycle N+1.
  - With no stall, the register file captures it at edge N+1.
  - Minimum end-to-end latency is one cycle.
- **Ordering.** Writes drain in acceptance order, so the last write to a register wins.
- **Throughput.** Sustained one result per cycle. A stalled queue fills in `DEPTH` accepts, then both ready outputs are low.

## Configuration
- `WBQ_FWD_EN` defined: forwarding lookup logic is compiled in as described above.
- `WBQ_FWD_EN` undefined: no comparators are built; `fwd_hit1/2` and `fwd_data1/2` are tied to 0. The operand stage must then stall on hazards.

## Test plan
- **Reset and empty.** Reset, then idle → `count=0`, `rf_reg_write=0`, `mem_ready=alu_ready=1`.
- **Single ALU write.** `alu_valid`, `alu_reg=3`, `alu_data=0x1234` for one cycle → next cycle `rf_reg_write=1`, `rf_write_reg=3`, `rf_write_data=0x1234`, then `count` returns to 0.
- **Priority and R0 filter.**
  - Same cycle mem (R5, 0x00AA) and ALU (R6, 0x00BB) → mem accepted and `alu_ready=0`; ALU accepted the next cycle; writes drain R5 then R6.
  - ALU write to R0 → accepted, `count` stays 0, no `rf_reg_write`.
- **Full, stall and wrap.** Hold `wb_stall=1` and enqueue R1..R4 = 1..4 → `full=1`, both ready low, R5 not accepted. Release the stall → R1..R4 drain in order on consecutive cycles. Enqueue 6 more entries while draining → pointers wrap and order is preserved.
- **Forwarding (`WBQ_FWD_EN`).** Stall and enqueue R7=0x0011 then R7=0x0022, with `fwd_reg1=7` and `fwd_reg2=8` → `fwd_hit1=1`, `fwd_data1=0x0022`, `fwd_hit2=0`, `fwd_data2=0`. Without the macro, both hit outputs are 0.
- **Reset mid-operation.** Three entries pending, assert `reset_n=0` mid-cycle → `rf_reg_write` and `count` drop to 0 without waiting for a clock edge, and no pending write reaches the register file after release.
